// File: rtl/vic20_pkg.sv
// Shared types and constants for the download sequencer.
// Holds the loader FSM state enum, the BASIC end-of-program pointer
// address list, the default cartridge base and the pointer byte selector.
package vic20_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_DRAIN,
    ST_INJECT,
    ST_WAIT_RST
  } prg_state_t;

  localparam logic [15:0] CART_BASE_DFLT = 16'hA000;

  localparam int PTR_CNT = 8;

  // BASIC pointers that all receive the end-of-program address:
  // VARTAB, ARYTAB, STREND (zero page) and the load-end pointer at $AE.
  localparam logic [15:0] PTR_ADDR [0:7] = '{
    16'h002D, 16'h002E, 16'h002F, 16'h0030,
    16'h0031, 16'h0032, 16'h00AE, 16'h00AF
  };

  // Even pointer slots carry the low byte, odd slots the high byte.
  function automatic logic [7:0] ptr_byte(input logic [15:0] end_addr,
                                          input logic [2:0]  idx);
    return idx[0] ? end_addr[15:8] : end_addr[7:0];
  endfunction

endpackage

// File: rtl/prg_loader_if.sv
// Memory write port between the loader and the shared memory arbiter.
// master: drives mem_req/mem_addr/mem_data, receives mem_ack.
// slave: memory side; returns a one-cycle mem_ack per accepted request.
interface prg_loader_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, output mem_data, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_data, output mem_ack);

endinterface

// File: rtl/byte_skid.sv
// Single-entry {addr, data} holding register driving a req/ack write port.
// Latency: entry loaded in cycle N is requested from cycle N+1.
// Backpressure: load_rdy is high when empty or when the entry is being acked.
// Ports: clk/rst_n; load/load_addr/load_data in; ack in; full/addr/data out.
module byte_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic        ack,
  output logic        load_rdy,
  output logic        full,
  output logic [15:0] addr,
  output logic [7:0]  data
);

  // An ack only counts while the entry is occupied; a stray ack is ignored.
  assign load_rdy = !full || ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= 16'h0000;
      data <= 8'h00;
    end else if (load) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (ack && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/prg_loader.sv
// Download sequencer: PRG header/raw-cart parsing, payload write-out to memory,
// then BASIC end pointer injection and optional delayed reset request.
// Backpressure: a byte arriving while the single entry is busy is dropped (overflow).
// Ports: clk_sys/reset_n; data_io stream (downloading, index, wr, addr, din,
// raw_mode); mem (memory write port, master); busy, force_reset, overflow.
module prg_loader
  import vic20_pkg::*;
#(
  parameter int          RESET_DELAY = 16,
  parameter logic [15:0] CART_BASE   = CART_BASE_DFLT
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               downloading,
  input  logic [7:0]         index,
  input  logic               wr,
  input  logic [15:0]        addr,
  input  logic [7:0]         din,
  input  logic               raw_mode,
  prg_loader_if.master       mem,
  output logic               busy,
  output logic               force_reset,
  output logic               overflow
);

  localparam logic [15:0] DLY_LAST = 16'(RESET_DELAY - 1);
  localparam logic [3:0]  INJ_END  = 4'(PTR_CNT);

  prg_state_t  state, state_nxt;
  logic        dl_q;
  logic [15:0] load_addr, load_addr_nxt;
  logic [15:0] cur, cur_nxt;
  logic        auto_rst, auto_rst_nxt;
  logic        overflow_nxt;
  logic [3:0]  inj_cnt, inj_cnt_nxt;
  logic [15:0] dly_cnt, dly_cnt_nxt;

  logic        sk_load;
  logic [15:0] sk_addr;
  logic [7:0]  sk_data;
  logic        sk_rdy;
  logic        sk_full;

  logic        dl_rise, dl_fall, raw_sel;

  // The payload position comes from cur, not from the file offset.
  logic        unused_addr;
  assign unused_addr = ^addr;

  assign dl_rise = downloading && !dl_q;
  assign dl_fall = !downloading && dl_q;
  // Index 1 is always a PRG, whatever raw_mode says.
  assign raw_sel = raw_mode && (index[4:0] != 5'd1);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load_addr_nxt = load_addr;
    cur_nxt       = cur;
    auto_rst_nxt  = auto_rst;
    overflow_nxt  = overflow;
    inj_cnt_nxt   = inj_cnt;
    dly_cnt_nxt   = dly_cnt;
    sk_load       = 1'b0;
    sk_addr       = cur;
    sk_data       = din;
    force_reset   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (dl_rise && index != 8'd0) begin
          overflow_nxt = 1'b0;
          if (raw_sel) begin
            cur_nxt   = CART_BASE;
            state_nxt = ST_DATA;
          end else begin
            state_nxt = ST_HDR_LO;
          end
        end
      end
      ST_HDR_LO: begin
        if (dl_fall) begin
          state_nxt = ST_IDLE;
        end else if (wr) begin
          load_addr_nxt[7:0] = din;
          state_nxt          = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (dl_fall) begin
          state_nxt = ST_IDLE;
        end else if (wr) begin
          load_addr_nxt[15:8] = din;
          cur_nxt             = {din, load_addr[7:0]};
          state_nxt           = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wr) begin
          if (sk_rdy) begin
            sk_load = 1'b1;
            if (cur == CART_BASE) auto_rst_nxt = 1'b1;
          end else begin
            overflow_nxt = 1'b1;
          end
          // Dropped bytes still occupy their address slot.
          cur_nxt = cur + 16'd1;
        end
        if (dl_fall) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!sk_full) begin
          inj_cnt_nxt = 4'd0;
          state_nxt   = ST_INJECT;
        end
      end
      ST_INJECT: begin
        if (inj_cnt != INJ_END) begin
          if (!sk_full) begin
            sk_load     = 1'b1;
            sk_addr     = PTR_ADDR[inj_cnt[2:0]];
            sk_data     = ptr_byte(cur, inj_cnt[2:0]);
            inj_cnt_nxt = inj_cnt + 4'd1;
          end
        end else if (sk_full && mem.mem_ack) begin
          // Delay count starts from the ack of the final pointer byte.
          dly_cnt_nxt = 16'd0;
          state_nxt   = ST_WAIT_RST;
        end
      end
      ST_WAIT_RST: begin
        if (dly_cnt == DLY_LAST) begin
          force_reset  = auto_rst;
          auto_rst_nxt = 1'b0;
          state_nxt    = ST_IDLE;
        end else begin
          dly_cnt_nxt = dly_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q      <= 1'b0;
      load_addr <= 16'h0000;
      cur       <= 16'h0000;
      auto_rst  <= 1'b0;
      overflow  <= 1'b0;
      inj_cnt   <= 4'd0;
      dly_cnt   <= 16'd0;
    end else begin
      dl_q      <= downloading;
      load_addr <= load_addr_nxt;
      cur       <= cur_nxt;
      auto_rst  <= auto_rst_nxt;
      overflow  <= overflow_nxt;
      inj_cnt   <= inj_cnt_nxt;
      dly_cnt   <= dly_cnt_nxt;
    end
  end

  // Payload and pointer writes share the one holding entry.
  byte_skid u_skid (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .load      (sk_load),
    .load_addr (sk_addr),
    .load_data (sk_data),
    .ack       (mem.mem_ack),
    .load_rdy  (sk_rdy),
    .full      (sk_full),
    .addr      (mem.mem_addr),
    .data      (mem.mem_data)
  );

  assign mem.mem_req = sk_full;

endmodule

// File: tb/tb_prg_loader.sv
// Bench for prg_loader: directed file downloads plus randomized files,
// memory-side responder with programmable ack delay, and a reference model
// that derives the expected write list from load address and payload bytes.
module tb_prg_loader;

  localparam int          RESET_DELAY = 16;
  localparam logic [15:0] CART        = 16'hA000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        downloading = 1'b0;
  logic [7:0]  index = 8'd0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [7:0]  din = 8'd0;
  logic        raw_mode = 1'b0;
  logic        busy, force_reset, overflow;

  prg_loader_if mem ();

  prg_loader #(.RESET_DELAY(RESET_DELAY), .CART_BASE(CART)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .downloading (downloading),
    .index       (index),
    .wr          (wr),
    .addr        (addr),
    .din         (din),
    .raw_mode    (raw_mode),
    .mem         (mem),
    .busy        (busy),
    .force_reset (force_reset),
    .overflow    (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [15:0] ptrs [8] = '{16'h002D, 16'h002E, 16'h002F, 16'h0030,
                            16'h0031, 16'h0032, 16'h00AE, 16'h00AF};

  // memory-side log
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          ack_cyc = 0;
  int          fr_count = 0;
  int          fr_cyc = 0;
  int          stab_err = 0;
  int          ack_delay = 2;
  logic        ack_hold = 1'b0;

  // expected
  logic [15:0] exp_a[$];
  logic [7:0]  exp_d[$];
  int          exp_fr = 0;
  logic [7:0]  file_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder: acks a request after ack_delay cycles of it being visible,
  // logs every acked write, and watches bus stability and force_reset.
  initial begin
    int age;
    logic just;
    logic prev_req;
    logic [23:0] prev_bus;
    age = 0; prev_req = 1'b0; prev_bus = 24'd0;
    mem.mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      just = 1'b0;
      if (prev_req && mem.mem_req && !mem.mem_ack &&
          ({mem.mem_addr, mem.mem_data} !== prev_bus)) stab_err++;
      prev_req = mem.mem_req;
      prev_bus = {mem.mem_addr, mem.mem_data};
      if (force_reset) begin fr_count++; fr_cyc = cyc; end
      if (mem.mem_ack) begin mem.mem_ack = 1'b0; age = 0; just = 1'b1; end
      if (mem.mem_req) age++; else age = 0;
      if (!just && mem.mem_req && !ack_hold && age >= ack_delay) begin
        mem.mem_ack = 1'b1;
        wa_q.push_back(mem.mem_addr);
        wd_q.push_back(mem.mem_data);
        ack_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); fr_count = 0;
  endtask

  task automatic drive_file(input logic [7:0] idx, input logic raw, input int gap);
    @(negedge clk_sys);
    index = idx; raw_mode = raw; downloading = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < file_q.size(); i++) begin
      wr = 1'b1; din = file_q[i]; addr = 16'(i);
      @(negedge clk_sys);
      wr = 1'b0;
      repeat (gap) @(negedge clk_sys);
    end
    downloading = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (busy && n < 4000);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk_sys);
  endtask

  // Expected writes: payload bytes from file_q[first..] at load, load+1, ...
  // (16-bit wrap), skipping payload indices drop_lo..drop_hi; then the eight
  // pointers holding load + payload length.
  task automatic build_exp(input logic [15:0] load, input int first,
                           input int drop_lo, input int drop_hi);
    logic [15:0] a;
    exp_a.delete(); exp_d.delete(); exp_fr = 0;
    a = load;
    for (int i = first; i < file_q.size(); i++) begin
      if (!((i - first) >= drop_lo && (i - first) <= drop_hi)) begin
        exp_a.push_back(a);
        exp_d.push_back(file_q[i]);
        if (a == CART) exp_fr = 1;
      end
      a = a + 16'd1;
    end
    for (int k = 0; k < 8; k++) begin
      exp_a.push_back(ptrs[k]);
      exp_d.push_back((k % 2 == 1) ? a[15:8] : a[7:0]);
    end
  endtask

  task automatic check_run(input string tag, input logic exp_ovf);
    int n;
    chk({tag, "_nwr"}, wa_q.size(), exp_a.size());
    n = (wa_q.size() < exp_a.size()) ? wa_q.size() : exp_a.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), {8'd0, wa_q[i], wd_q[i]}, {8'd0, exp_a[i], exp_d[i]});
    chk({tag, "_frcnt"}, fr_count, exp_fr);
    if (exp_fr != 0) chk({tag, "_frdly"}, fr_cyc - ack_cyc, RESET_DELAY);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},  {31'd0, mem.mem_req}, 32'd0);
    chk({tag, "_addr"}, {16'd0, mem.mem_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, mem.mem_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frst"}, {31'd0, force_reset}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    logic [7:0]  idx_tab [4];
    logic [15:0] ld;
    logic [7:0]  idx;
    logic        raw, use_raw;
    int          n, gap, t0;
    idx_tab = '{8'h01, 8'h02, 8'h03, 8'h41};

    // reset state
    repeat (3) @(negedge clk_sys);
    #1;
    check_reset_vals("reset");
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // PRG header $1001 with 3 bytes
    clear_logs(); ack_delay = 2;
    file_q = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    drive_file(8'h01, 1'b0, 3);
    wait_idle("prg");
    build_exp(16'h1001, 2, 1, 0);
    check_run("prg", 1'b0);

    // raw cart, 4 bytes, auto reset
    clear_logs();
    file_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_file(8'h02, 1'b1, 3);
    wait_idle("raw");
    build_exp(CART, 0, 1, 0);
    check_run("raw", 1'b0);
    chk("raw_auto", exp_fr, 1);

    // wr coinciding with ack on every byte: nothing dropped
    clear_logs(); ack_delay = 2;
    file_q = '{8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    drive_file(8'h01, 1'b0, 1);
    wait_idle("simul");
    build_exp(16'h4000, 2, 1, 0);
    check_run("simul", 1'b0);

    // ack held off: bytes 2 and 3 dropped, end still load+3
    clear_logs(); ack_delay = 1; ack_hold = 1'b1;
    file_q = '{8'h00, 8'h30, 8'h11, 8'h22, 8'h33};
    drive_file(8'h01, 1'b0, 0);
    repeat (3) @(negedge clk_sys);
    ack_hold = 1'b0;
    wait_idle("ovf");
    build_exp(16'h3000, 2, 1, 2);
    check_run("ovf", 1'b1);

    // address wrap $FFFF -> $0000
    clear_logs(); ack_delay = 2;
    file_q = '{8'hFF, 8'hFF, 8'h5A, 8'hA5};
    drive_file(8'h01, 1'b0, 3);
    wait_idle("wrap");
    build_exp(16'hFFFF, 2, 1, 0);
    check_run("wrap", 1'b0);

    // truncated header: nothing written
    clear_logs();
    file_q = '{8'h01};
    drive_file(8'h01, 1'b0, 3);
    wait_idle("trunc");
    exp_a.delete(); exp_d.delete(); exp_fr = 0;
    check_run("trunc", 1'b0);

    // index 0 (ROM) is ignored
    clear_logs();
    file_q = '{8'h01, 8'h10, 8'hAA};
    drive_file(8'h00, 1'b0, 3);
    wait_idle("rom");
    exp_a.delete(); exp_d.delete(); exp_fr = 0;
    check_run("rom", 1'b0);

    // reset during pointer injection
    clear_logs(); ack_delay = 2;
    file_q = '{8'h00, 8'h20, 8'h77, 8'h88};
    drive_file(8'h01, 1'b0, 3);
    t0 = 0;
    while (wa_q.size() < 5 && t0 < 2000) begin
      @(negedge clk_sys);
      t0++;
    end
    chk("rstinj_reach", {31'd0, wa_q.size() >= 5}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rstinj");
    repeat (10) @(negedge clk_sys);
    chk("rstinj_nomore", wa_q.size(), 5);
    chk("rstinj_nofr", fr_count, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    clear_logs();
    file_q = '{8'hC1, 8'hC2};
    drive_file(8'h03, 1'b1, 3);
    wait_idle("after");
    build_exp(CART, 0, 1, 0);
    check_run("after", 1'b0);

    // randomized files
    for (int t = 0; t < 8; t++) begin
      clear_logs();
      idx       = idx_tab[$urandom_range(0, 3)];
      raw       = 1'($urandom_range(0, 1));
      use_raw   = raw && (idx[4:0] != 5'd1);
      n         = $urandom_range(0, 5);
      gap       = $urandom_range(2, 4);
      ack_delay = $urandom_range(1, 3);
      ld        = 16'($urandom);
      if (t == 2) ld = CART - 16'd1;
      file_q.delete();
      if (!use_raw) begin
        file_q.push_back(ld[7:0]);
        file_q.push_back(ld[15:8]);
      end
      for (int i = 0; i < n; i++) file_q.push_back(8'($urandom));
      drive_file(idx, raw, gap);
      wait_idle($sformatf("rnd%0d", t));
      build_exp(use_raw ? CART : ld, use_raw ? 0 : 2, 1, 0);
      check_run($sformatf("rnd%0d", t), 1'b0);
    end

    chk("bus_stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
